regfile_access_arbiter: RTL

- Shares the 8x8 three-port register file (two read ports, one write port, combinational read, clocked write on clk) between NREQ requesters.
- Each requester issues either a dual-register read or a single-register write through a valid/ready handshake; the arbiter grants round-robin and serialises operations.
- Enforces the register-file rule: in any cycle the file performs either a read or a write, never both.
- Sits between the processor's issue/decode units and the register file instance.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/regfile_access_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the register-file access arbiter.
package regfile_pkg;

  localparam int RF_DW    = 8;
  localparam int RF_AW    = 3;
  localparam int RF_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } rf_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant     = NREQ'(1) << idx;
        grant_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Serialises read/write requests from NREQ requesters onto one shared 8x8 register file.
module regfile_access_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*AW-1:0]       req_addr_a,
  input  logic [NREQ*AW-1:0]       req_addr_b,
  input  logic [NREQ*DW-1:0]       req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_write,
  output logic [DW-1:0]            rsp_data_1,
  output logic [DW-1:0]            rsp_data_2,
  output logic [AW-1:0]            rf_read_port_1,
  output logic [AW-1:0]            rf_read_port_2,
  output logic [AW-1:0]            rf_write_port_1,
  output logic                     rf_write_enable,
  output logic [DW-1:0]            rf_write_data,
  input  logic [DW-1:0]            rf_read_data_1,
  input  logic [DW-1:0]            rf_read_data_2
);

  localparam int IW = $clog2(NREQ);

  rf_state_t       state, state_next;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            accept;
  logic            op_write;
  logic [AW-1:0]   cap_a, cap_b;
  logic [DW-1:0]   cap_wdata;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The grant is always one of the valid requesters, so any request in IDLE is a handshake.
  assign accept = (state == IDLE) && (|req_valid) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      op_write   <= 1'b0;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_wdata  <= '0;
      rsp_id     <= '0;
      rsp_write  <= 1'b0;
      rsp_data_1 <= '0;
      rsp_data_2 <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_write  <= req_write[grant_idx];
        cap_a     <= req_addr_a[grant_idx*AW +: AW];
        cap_b     <= req_addr_b[grant_idx*AW +: AW];
        cap_wdata <= req_wdata[grant_idx*DW +: DW];
        rsp_id    <= grant_idx;
        rsp_write <= req_write[grant_idx];
        ptr       <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
      end
      if (state == ISSUE && !op_write) begin
        rsp_data_1 <= rf_read_data_1;
        rsp_data_2 <= rf_read_data_2;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req_valid) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rst gates the combinational outputs so a write in ISSUE is squashed in the reset cycle.
  always_comb begin
    req_ready       = '0;
    rsp_valid       = 1'b0;
    rf_write_enable = 1'b0;
    rf_read_port_1  = cap_a;
    rf_read_port_2  = cap_b;
    rf_write_port_1 = cap_a;
    rf_write_data   = cap_wdata;
    if (!rst) begin
      if (state == IDLE)  req_ready = grant;
      if (state == RESP)  rsp_valid = 1'b1;
      if (state == ISSUE) rf_write_enable = op_write;
    end
  end

endmodule
